// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: bus typedefs, the canonical NOP encoding,
// the {pc,inst} buffer entry and a word-align helper.
package if_fetch_pkg;

    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    localparam InstBus     RV_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    typedef struct packed {
        InstAddrBus pc;
        InstBus     inst;
    } fetch_entry_t;

    function automatic InstAddrBus pc_align(input InstAddrBus a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO of {pc,inst} entries for the fetch stage.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push/din          write an entry (ignored when full and not popping)
//   pop/dout          dout is the head; pop removes it (ignored when empty)
//   flush             empties the FIFO; wins over a same-cycle push
//   count/empty/full  occupancy
module if_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fetch_entry_t            din,
    output fetch_entry_t            dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        // A full FIFO can still accept when the head leaves the same cycle.
        do_push  = push && (!full || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage.
// Issues sequential word-aligned fetches, buffers in-order responses with
// their PCs in an if_fifo, and presents them to decode via valid/ready.
// A redirect flushes the buffer and restarts fetch; responses to requests
// already in flight at that point are counted and dropped.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_o/addr_o/gnt_i       request channel (gnt same cycle as req)
//   imem_rvalid_i/rdata_i         in-order response channel
//   redirect_i/redirect_pc_i      flush and restart fetch
//   id_valid_o/ready_i/pc_o/inst_o  decode handshake
// Optional (macro IF_PERF_EN): perf_ret_o (pops), perf_bubble_o
//   (cycles with ready && !valid); saturating, cleared by rst.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_ret_o,
    output logic [31:0] perf_bubble_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    InstAddrBus    fetch_pc_q, fetch_pc_d;
    InstAddrBus    resp_pc_q, resp_pc_d;
    InstAddrBus    last_pc_q, last_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;
    logic          fifo_push, fifo_pop;
    fetch_entry_t  fifo_din, fifo_head;
    logic [CW:0]   credits_used;
    logic          req_fire, rsp_keep;

    // Every request in flight owns a future FIFO slot, so outstanding plus
    // buffered entries may never exceed the depth.
    assign credits_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_o   = !rst && !redirect_i && (credits_used < (CW+1)'(FIFO_DEPTH));
    assign imem_addr_o  = fetch_pc_q;
    assign req_fire     = imem_req_o && imem_gnt_i;

    assign rsp_keep      = imem_rvalid_i && (discard_q == '0);
    assign fifo_push     = rsp_keep;
    assign fifo_din.pc   = resp_pc_q;
    assign fifo_din.inst = imem_rdata_i;
    assign fifo_pop      = id_valid_o && id_ready_i;

    assign id_valid_o = !fifo_empty;
    assign id_pc_o    = fifo_empty ? last_pc_q : fifo_head.pc;
    assign id_inst_o  = fifo_empty ? RV_NOP_INST : fifo_head.inst;

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_i),
        .din   (fifo_din),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        last_pc_d     = id_pc_o;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rvalid_i);
        if (imem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_keep) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
        // Everything still owed by memory after this cycle is stale,
        // including anything granted earlier but not yet returned.
        if (redirect_i) begin
            fetch_pc_d = pc_align(redirect_pc_i);
            resp_pc_d  = pc_align(redirect_pc_i);
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            last_pc_q     <= ZeroWord;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            last_pc_q     <= last_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] perf_ret_q, perf_ret_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_ret_d    = perf_ret_q;
        perf_bubble_d = perf_bubble_q;
        if (fifo_pop && (perf_ret_q != 32'hFFFF_FFFF)) begin
            perf_ret_d = perf_ret_q + 32'd1;
        end
        if (id_ready_i && !id_valid_o && (perf_bubble_q != 32'hFFFF_FFFF)) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ret_q    <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_ret_q    <= perf_ret_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_ret_o    = perf_ret_q;
    assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
`ifdef IF_PERF_EN
    logic [31:0] perf_ret_o;
    logic [31:0] perf_bubble_o;
`endif

    if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o)
`ifdef IF_PERF_EN
        ,
        .perf_ret_o    (perf_ret_o),
        .perf_bubble_o (perf_bubble_o)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: in-order queue of granted addresses with due cycles.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t memq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_due = 0;

    // Drive knobs set by the sequences before each step.
    logic        b_rst   = 1'b1;
    logic        b_redir = 1'b0;
    logic [31:0] b_rpc   = '0;
    logic        b_ready = 1'b1;
    logic        b_gnt   = 1'b1;
    int          lat     = 1;
    bit          scramble = 1'b0;

    // Reference: decode must see an unbroken +4 stream from the last
    // restart point, each word being the memory contents at that pc.
    logic [31:0] exp_pc    = RESET_PC;
    logic [31:0] fetch_exp = RESET_PC;
    logic [31:0] last_pc   = '0;
    bit          want_first = 1'b0;
    logic [31:0] want_pc   = '0;
    int          pops = 0;
    int          bubbles = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return scramble ? (a ^ 32'hDEAD_BEEF) : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        mreq_t m;
        int    due;
        @(negedge clk);
        rst           = b_rst;
        redirect_i    = b_redir;
        redirect_pc_i = b_rpc;
        id_ready_i    = b_ready;
        imem_gnt_i    = b_gnt;
        if (!b_rst && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memfn(memq[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
        if (b_rst) begin
            memq.delete();
            last_due  = cyc;
            exp_pc    = RESET_PC;
            fetch_exp = RESET_PC;
            last_pc   = '0;
            pops      = 0;
            bubbles   = 0;
            chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        end else begin
            if (!id_valid_o) chk("nop_when_idle", id_inst_o, NOP);
            if (imem_req_o) chk("fetch_addr", imem_addr_o, fetch_exp);
            if (b_redir) chk("req_off_redir", {31'b0, imem_req_o}, 32'd0);
            if (id_valid_o && id_ready_i) pops++;
            if (id_ready_i && !id_valid_o) bubbles++;
            if (id_valid_o && id_ready_i && !b_redir) begin
                chk("deliv_pc", id_pc_o, exp_pc);
                chk("deliv_inst", id_inst_o, memfn(exp_pc));
                if (want_first) begin
                    chk("first_after_redir", id_pc_o, want_pc);
                    want_first = 1'b0;
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (id_valid_o) last_pc = id_pc_o;
            else chk("hold_pc", id_pc_o, last_pc);
            if (imem_rvalid_i) void'(memq.pop_front());
            if (imem_req_o && imem_gnt_i) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                m.addr = imem_addr_o;
                m.due  = due;
                memq.push_back(m);
                last_due  = due;
                fetch_exp = fetch_exp + 32'd4;
            end
            chk("inflight_cap", {31'b0, memq.size() <= DEPTH}, 32'd1);
            if (b_redir) begin
                exp_pc    = {b_rpc[31:2], 2'b00};
                fetch_exp = {b_rpc[31:2], 2'b00};
            end
        end
        cyc++;
    endtask

    task automatic chk_reset_state();
        chk("rst_addr", imem_addr_o, RESET_PC);
        chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
        chk("rst_pc", id_pc_o, 32'd0);
        chk("rst_inst", id_inst_o, NOP);
    endtask

    initial begin
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;

        // 1: reset, then 1-cycle memory returning addr as data.
        b_rst = 1'b1;
        repeat (3) step();
        chk_reset_state();
        b_rst = 1'b0; b_gnt = 1'b1; lat = 1; b_ready = 1'b1;
        step();
        chk("t1_req", {31'b0, imem_req_o}, 32'd1);
        chk("t1_addr0", imem_addr_o, 32'd0);
        step();
        chk("t1_valid_early", {31'b0, id_valid_o}, 32'd0);
        step();
        chk("t1_valid", {31'b0, id_valid_o}, 32'd1);
        chk("t1_pc0", id_pc_o, 32'd0);
        chk("t1_inst0", id_inst_o, 32'd0);
        step();
        chk("t1_pc4", id_pc_o, 32'd4);
        repeat (6) step();

        // 2: stall decode; credits run out and request drops.
        b_ready = 1'b0; lat = 2;
        repeat (10) step();
        chk("t2_req_off", {31'b0, imem_req_o}, 32'd0);
        chk("t2_valid", {31'b0, id_valid_o}, 32'd1);
        b_ready = 1'b1;
        repeat (8) step();

        // 3: redirect with two requests in flight.
        lat = 4;
        for (int i = 0; i < 20; i++) begin
            if (memq.size() == DEPTH) break;
            step();
        end
        chk("t3_inflight", memq.size(), DEPTH);
        b_redir = 1'b1; b_rpc = 32'h0000_0100;
        want_first = 1'b1; want_pc = 32'h0000_0100;
        step();
        b_redir = 1'b0;
        repeat (20) step();
        chk("t3_first_seen", {31'b0, want_first}, 32'd0);

        // 4: unaligned redirect target, best-case latency from idle memory.
        b_gnt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (memq.size() == 0) break;
            step();
        end
        chk("t4_drained", memq.size(), 0);
        lat = 1; b_gnt = 1'b1;
        b_redir = 1'b1; b_rpc = 32'h0000_0203;
        step();
        b_redir = 1'b0;
        step();
        chk("t4_req", {31'b0, imem_req_o}, 32'd1);
        chk("t4_addr", imem_addr_o, 32'h0000_0200);
        chk("t4_valid_t1", {31'b0, id_valid_o}, 32'd0);
        step();
        chk("t4_valid_t2", {31'b0, id_valid_o}, 32'd0);
        step();
        chk("t4_valid_t3", {31'b0, id_valid_o}, 32'd1);
        chk("t4_pc", id_pc_o, 32'h0000_0200);
        chk("t4_inst", id_inst_o, 32'h0000_0200);
        repeat (5) step();

        // 5: redirect coincident with rvalid, then a second redirect.
        lat = 2;
        for (int i = 0; i < 20; i++) begin
            if (memq.size() > 0 && memq[0].due <= cyc) break;
            step();
        end
        b_redir = 1'b1; b_rpc = 32'h0000_0180;
        step();
        b_rpc = 32'h0000_0300;
        want_first = 1'b1; want_pc = 32'h0000_0300;
        step();
        b_redir = 1'b0;
        repeat (20) step();
        chk("t5_first_seen", {31'b0, want_first}, 32'd0);

        // 6: mid-operation reset, then randomized traffic.
        b_rst = 1'b1;
        repeat (2) step();
        chk_reset_state();
        scramble = 1'b1;
        b_rst = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            b_gnt   = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 3) != 0);
            lat     = $urandom_range(1, 5);
            b_redir = ($urandom_range(0, 63) == 0);
            b_rpc   = $urandom;
            step();
        end

`ifdef IF_PERF_EN
        @(negedge clk);
        #1;
        chk("perf_ret", perf_ret_o, pops);
        chk("perf_bubble", perf_bubble_o, bubbles);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
